dds_ctrl: RTL and testbench

DDS_CTRL -- requirements
Module: dds_ctrl

---
 rtl/dds_ctrl_pkg.sv | 43 ++++
 rtl/dds_freq_lut.sv | 28 ++
 rtl/dds_ctrl.sv | 157 +++++++++++++++
 tb/tb_dds_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dds_ctrl_pkg.sv
// rtl/dds_ctrl_pkg.sv - shared DDS definitions: wave codes, step count, frequency table, FSM states
//
// Purpose: single source of truth for the DDS control slice. Holds the
// 1-2-5 frequency table, the waveform codes, the controller state encoding
// and the tuning-word rounding helper used by both the ROM and the reset value.
// Ports: none (package).

package dds_ctrl_pkg;

  localparam int NUM_STEPS = 16;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_TRI    = 2'd1,
    WAVE_SAW    = 2'd2,
    WAVE_SQUARE = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_LOAD   = 2'd3
  } state_e;

  // 100 Hz .. 10 MHz in a 1-2-5 progression.
  localparam logic [63:0] FREQ_HZ [NUM_STEPS] = '{
    64'd100,     64'd200,     64'd500,
    64'd1000,    64'd2000,    64'd5000,
    64'd10000,   64'd20000,   64'd50000,
    64'd100000,  64'd200000,  64'd500000,
    64'd1000000, 64'd2000000, 64'd5000000,
    64'd10000000
  };

  // Round-to-nearest of f * 2^acc_w / clk. 64-bit headroom covers 10 MHz at 32 bits.
  function automatic logic [63:0] tuning_word(input logic [63:0] f_hz,
                                              input logic [63:0] clk_hz,
                                              input int          acc_w);
    return ((f_hz << acc_w) + (clk_hz >> 1)) / clk_hz;
  endfunction

endpackage

// File: rtl/dds_freq_lut.sv
// rtl/dds_freq_lut.sv - combinational tuning-word ROM indexed by frequency step
//
// Purpose: maps a 4-bit frequency index to the phase-increment word for the
// configured sample clock. All entries are elaboration-time constants.
// Ports:
//   idx_i  [3:0]        frequency index 0..15
//   word_o [ACC_W-1:0]  tuning word for that index

module dds_freq_lut
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ = 72000000,
  parameter int          ACC_W  = 32
) (
  input  logic [3:0]       idx_i,
  output logic [ACC_W-1:0] word_o
);

  logic [ACC_W-1:0] rom [NUM_STEPS];

  for (genvar k = 0; k < NUM_STEPS; k++) begin : g_rom
    localparam logic [63:0] TW = tuning_word(FREQ_HZ[k], 64'(CLK_HZ), ACC_W);
    assign rom[k] = TW[ACC_W-1:0];
  end

  assign word_o = rom[idx_i];

endmodule

// File: rtl/dds_ctrl.sv
// rtl/dds_ctrl.sv - button-driven DDS frequency/waveform controller
//
// Purpose: turns debounced Up/Down/Mode pulses into a registered tuning word,
// waveform code and frequency index, with a one-cycle Update strobe when the
// outputs change. Pulses seen while a request is in flight are held one-deep.
// Ports:
//   Fg_CLK            sample clock
//   RESETn            asynchronous active-low reset
//   BtnUp/BtnDown     one-cycle pulses, step frequency index up/down (saturating)
//   BtnMode           one-cycle pulse, advance waveform (wrapping)
//   PhaseInc [ACC_W]  tuning word
//   WaveSel  [2]      0 sine, 1 triangle, 2 saw, 3 square
//   FreqIdx  [4]      current frequency index
//   Update            high for the one cycle new outputs first appear

module dds_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 72000000,
  parameter int          ACC_W   = 32,
  parameter int          DEF_IDX = 3
) (
  input  logic             Fg_CLK,
  input  logic             RESETn,
  input  logic             BtnUp,
  input  logic             BtnDown,
  input  logic             BtnMode,
  output logic [ACC_W-1:0] PhaseInc,
  output logic [1:0]       WaveSel,
  output logic [3:0]       FreqIdx,
  output logic             Update
);

  localparam logic [3:0]  MAX_IDX  = 4'(NUM_STEPS - 1);
  localparam logic [3:0]  RST_IDX  = 4'(DEF_IDX);
  localparam logic [63:0] RST_TW   = tuning_word(FREQ_HZ[DEF_IDX], 64'(CLK_HZ), ACC_W);
  localparam logic [ACC_W-1:0] RST_WORD = RST_TW[ACC_W-1:0];

  // Request vectors are {mode, down, up}.
  state_e           state_q, state_d;
  logic [2:0]       pend_q, pend_d;
  logic [2:0]       req_q, req_d;
  logic [3:0]       nidx_q, nidx_d;
  wave_e            nwave_q, nwave_d;
  logic [ACC_W-1:0] word_q, word_d;
  logic [ACC_W-1:0] phase_q, phase_d;
  wave_e            wave_q, wave_d;
  logic [3:0]       idx_q, idx_d;
  logic             update_q, update_d;

  logic [2:0]       live;
  logic [2:0]       req_in;
  logic [ACC_W-1:0] lut_word;

  assign live   = {BtnMode, BtnDown, BtnUp};
  assign req_in = live | pend_q;

  dds_freq_lut #(
    .CLK_HZ (CLK_HZ),
    .ACC_W  (ACC_W)
  ) u_lut (
    .idx_i  (nidx_q),
    .word_o (lut_word)
  );

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    req_d    = req_q;
    nidx_d   = nidx_q;
    nwave_d  = nwave_q;
    word_d   = word_q;
    phase_d  = phase_q;
    wave_d   = wave_q;
    idx_d    = idx_q;
    update_d = 1'b0;

    // Anything arriving while busy is remembered; repeats simply merge.
    if (state_q != ST_IDLE) begin
      pend_d = pend_q | live;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (req_in != 3'b000) begin
          req_d   = req_in;
          pend_d  = 3'b000;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        nidx_d = idx_q;
        // Up and Down together cancel; each saturates at its end of the table.
        if (req_q[0] && !req_q[1] && (idx_q != MAX_IDX)) begin
          nidx_d = idx_q + 4'd1;
        end else if (req_q[1] && !req_q[0] && (idx_q != 4'd0)) begin
          nidx_d = idx_q - 4'd1;
        end
        nwave_d = wave_q;
        if (req_q[2]) begin
          nwave_d = (wave_q == WAVE_SQUARE) ? WAVE_SINE : wave_e'(wave_q + 2'd1);
        end
        // A request that changes nothing finishes silently.
        if ((nidx_d == idx_q) && (nwave_d == wave_q)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        word_d  = lut_word;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // All three outputs move together from staged registers.
        phase_d  = word_q;
        wave_d   = nwave_q;
        idx_d    = nidx_q;
        update_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= ST_IDLE;
      pend_q   <= 3'b000;
      req_q    <= 3'b000;
      nidx_q   <= RST_IDX;
      nwave_q  <= WAVE_SINE;
      word_q   <= RST_WORD;
      phase_q  <= RST_WORD;
      wave_q   <= WAVE_SINE;
      idx_q    <= RST_IDX;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      req_q    <= req_d;
      nidx_q   <= nidx_d;
      nwave_q  <= nwave_d;
      word_q   <= word_d;
      phase_q  <= phase_d;
      wave_q   <= wave_d;
      idx_q    <= idx_d;
      update_q <= update_d;
    end
  end

  assign PhaseInc = phase_q;
  assign WaveSel  = wave_q;
  assign FreqIdx  = idx_q;
  assign Update   = update_q;

endmodule

// File: tb/tb_dds_ctrl.sv
// tb/tb_dds_ctrl.sv - self-checking bench for dds_ctrl against a latency-level model

module tb_dds_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        up = 1'b0, dn = 1'b0, md = 1'b0;
  logic [31:0] PhaseInc;
  logic [1:0]  WaveSel;
  logic [3:0]  FreqIdx;
  logic        Update;

  dds_ctrl dut (
    .Fg_CLK   (clk),
    .RESETn   (rst_n),
    .BtnUp    (up),
    .BtnDown  (dn),
    .BtnMode  (md),
    .PhaseInc (PhaseInc),
    .WaveSel  (WaveSel),
    .FreqIdx  (FreqIdx),
    .Update   (Update)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int upd_cnt = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference tuning word from f = {1,2,5}[k%3] * 100 * 10^(k/3), rounded.
  function automatic longint tw(input int k);
    int  mult [3] = '{1, 2, 5};
    real f;
    f = mult[k % 3] * 100.0;
    for (int j = 0; j < k / 3; j++) f = f * 10.0;
    return longint'($rtoi(f * 4294967296.0 / 72.0e6 + 0.5));
  endfunction

  // Model: a request accepted when free lands 3 edges later if it changes
  // anything (free again 4 edges after acceptance), otherwise it is dropped
  // and the controller is free 2 edges after acceptance. Busy-time pulses
  // are remembered one-deep per button.
  int     m_idx, m_wave, p_idx, p_wave, free_in, apply_in;
  longint m_phase;
  bit     m_upd;
  bit [2:0] m_pend;

  task automatic m_reset();
    m_idx = 3; m_wave = 0; m_phase = tw(3); m_upd = 0;
    free_in = 0; apply_in = 0; m_pend = 3'b000; p_idx = 3; p_wave = 0;
  endtask

  task automatic m_step();
    bit [2:0] live, r;
    int ni, nw;
    live  = {md, dn, up};
    m_upd = 0;
    if (apply_in > 0) begin
      apply_in--;
      if (apply_in == 0) begin
        m_idx = p_idx; m_wave = p_wave; m_phase = tw(p_idx); m_upd = 1;
      end
    end
    if (free_in == 0) begin
      r = live | m_pend;
      if (r != 3'b000) begin
        m_pend = 3'b000;
        ni = m_idx;
        if (r[0] && !r[1] && ni < 15) ni++;
        else if (r[1] && !r[0] && ni > 0) ni--;
        nw = r[2] ? (m_wave + 1) % 4 : m_wave;
        if (ni != m_idx || nw != m_wave) begin
          p_idx = ni; p_wave = nw; apply_in = 3; free_in = 3;
        end else begin
          free_in = 1;
        end
      end
    end else begin
      m_pend |= live;
      free_in--;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  always @(negedge clk) begin
    if (Update === 1'b1) upd_cnt++;
    if (cmp_en) begin
      n_tests++;
      if (PhaseInc !== 32'(m_phase) || WaveSel !== 2'(m_wave) ||
          FreqIdx !== 4'(m_idx) || Update !== m_upd) begin
        n_fail++;
        $display("FAIL cycle@%0t: got inc=%0d wave=%0d idx=%0d upd=%0d expected inc=%0d wave=%0d idx=%0d upd=%0d",
                 $time, PhaseInc, WaveSel, FreqIdx, Update, m_phase, m_wave, m_idx, m_upd);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic pulse(input bit u, input bit d, input bit m);
    up = u; dn = d; md = m;
    tick(1);
    up = 1'b0; dn = 1'b0; md = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  int u0;
  int exp_wave [4] = '{1, 2, 3, 0};

  initial begin
    tick(2);
    cmp_en = 1'b1;
    check("rst_phase", PhaseInc, 59652);
    check("rst_idx", FreqIdx, 3);
    check("rst_wave", WaveSel, 0);
    check("rst_update", Update, 0);
    rst_n = 1'b1;
    tick(3);
    check("no_update_on_release", upd_cnt, 0);

    // Single Up: Update exactly three edges after the sampling edge.
    pulse(1, 0, 0);
    check("lat_e0", Update, 0);
    tick(1); check("lat_e1", Update, 0);
    tick(1); check("lat_e2", Update, 0);
    tick(1);
    check("lat_e3_upd", Update, 1);
    check("lat_e3_idx", FreqIdx, 4);
    check("lat_e3_inc", PhaseInc, 119305);
    tick(1); check("lat_e4_upd", Update, 0);

    // Fifteen Downs from idx 3: only three produce an Update.
    do_reset();
    u0 = upd_cnt;
    repeat (15) begin
      pulse(0, 1, 0);
      tick(4);
    end
    tick(5);
    check("down_updates", upd_cnt - u0, 3);
    check("down_idx", FreqIdx, 0);
    check("down_inc", PhaseInc, 5965);

    // Up+Down cancel; adding Mode still applies the wave step.
    do_reset();
    u0 = upd_cnt;
    pulse(1, 1, 0);
    tick(6);
    check("cancel_updates", upd_cnt - u0, 0);
    check("cancel_inc", PhaseInc, 59652);
    u0 = upd_cnt;
    pulse(1, 1, 1);
    tick(6);
    check("cancel_mode_updates", upd_cnt - u0, 1);
    check("cancel_mode_wave", WaveSel, 1);
    check("cancel_mode_idx", FreqIdx, 3);

    // Up on three consecutive cycles: the busy-time repeats merge into one.
    do_reset();
    u0 = upd_cnt;
    up = 1'b1;
    tick(3);
    up = 1'b0;
    tick(12);
    check("merge_updates", upd_cnt - u0, 2);
    check("merge_idx", FreqIdx, 5);
    check("merge_inc", PhaseInc, 298262);

    // Mode wraps 3 -> 0.
    do_reset();
    u0 = upd_cnt;
    for (int i = 0; i < 4; i++) begin
      pulse(0, 0, 1);
      tick(4);
      check($sformatf("mode_wave%0d", i), WaveSel, exp_wave[i]);
    end
    check("mode_updates", upd_cnt - u0, 4);

    // Reset during LOOKUP aborts the request.
    do_reset();
    u0 = upd_cnt;
    pulse(1, 0, 0);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check("abort_inc", PhaseInc, 59652);
    check("abort_idx", FreqIdx, 3);
    rst_n = 1'b1;
    tick(10);
    check("abort_updates", upd_cnt - u0, 0);
    check("abort_idx_after", FreqIdx, 3);

    // Random pulses with occasional resets, checked cycle by cycle.
    for (int i = 0; i < 3000; i++) begin
      up    = ($urandom_range(0, 7) == 0);
      dn    = ($urandom_range(0, 9) == 0);
      md    = ($urandom_range(0, 11) == 0);
      rst_n = ($urandom_range(0, 599) != 0);
      tick(1);
    end
    up = 1'b0; dn = 1'b0; md = 1'b0; rst_n = 1'b1;
    tick(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
